// File: rtl/phy_tx_sequencer_pkg.sv
// Shared encodings for the PHY TX sequencer and the packet editor it launches.
package phy_tx_sequencer_pkg;

    localparam int IFG_CYCLES_DEF = 300;

    typedef enum logic [2:0] {
        SOP_T         = 3'd0,
        SOP_P_T       = 3'd1,
        SOP_PP_T      = 3'd2,
        HARD_RESET_T  = 3'd3,
        CABLE_RESET_T = 3'd4
    } sop_type_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GAP    = 2'd1,
        ST_START  = 2'd2,
        ST_ACTIVE = 2'd3
    } tx_state_e;

    function automatic logic is_reset_type(input logic [2:0] t);
        return (t == HARD_RESET_T) || (t == CABLE_RESET_T);
    endfunction

endpackage

// File: rtl/phy_tx_ifg_timer.sv
// Inter-frame gap timer: counts consecutive CC-idle cycles while enabled.
// Latency: done is combinational on the IFG_CYCLES-th consecutive idle cycle.
// Backpressure: none; CC activity or clr restarts the count from zero.
module phy_tx_ifg_timer
    import phy_tx_sequencer_pkg::*;
#(
    parameter int IFG_CYCLES = IFG_CYCLES_DEF,
    parameter int IFG_W      = 9
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic cc_busy,
    output logic done
);

    localparam logic [IFG_W-1:0] LAST = IFG_W'(IFG_CYCLES - 1);

    logic [IFG_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr || cc_busy) begin
            cnt <= '0;
        end else if (cnt != LAST) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign done = !clr && !cc_busy && (cnt == LAST);

endmodule

// File: rtl/phy_tx_sequencer.sv
// PHY TX sequencer: arbitrates Hard Reset > Cable Reset > message, enforces the IFG, launches the editor.
// Latency: request to phy_tx_packet_en is IFG_CYCLES+2 cycles; status pulses one cycle after encoder done.
// Backpressure: requests wait as level/pending flags; watchdog under PHY_TX_TIMEOUT_EN.
module phy_tx_sequencer
    import phy_tx_sequencer_pkg::*;
#(
    parameter int IFG_CYCLES = IFG_CYCLES_DEF,
    parameter int IFG_W      = 9
`ifdef PHY_TX_TIMEOUT_EN
    ,
    parameter int TMO_CYCLES = 65535,
    parameter int TMO_W      = 16
`endif
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pl2phy_tx_req,
    input  logic [2:0] pl2phy_tx_sop_type,
    input  logic       pl2phy_hardreset_req,
    input  logic       pl2phy_cablereset_req,
    input  logic       phy_rx_cc_busy,
    input  logic       phy_bmc_encoder_hold_lowbmc_done,
    output logic       phy_tx_packet_en,
    output logic [2:0] phy_tx_packet_type,
    output logic       phy2pl_tx_done,
    output logic       phy2pl_tx_discarded,
    output logic       phy2pl_reset_done,
    output logic       phy2pl_tx_err,
    output logic       phy_tx_busy
);

    tx_state_e state;
    logic      hr_pend, cr_pend;
    logic      hr_any, cr_any, msg_win, msg_req, gap_done, tmo_hit;

    assign hr_any  = hr_pend | pl2phy_hardreset_req;
    assign cr_any  = cr_pend | pl2phy_cablereset_req;
    assign msg_win = !is_reset_type(phy_tx_packet_type);
    // The protocol layer may still hold req during its own status pulse; ignore it that cycle.
    assign msg_req = pl2phy_tx_req && !(phy2pl_tx_done || phy2pl_tx_discarded || phy2pl_tx_err);
    assign phy_tx_busy = (state != ST_IDLE);

    phy_tx_ifg_timer #(
        .IFG_CYCLES (IFG_CYCLES),
        .IFG_W      (IFG_W)
    ) u_ifg (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (state != ST_GAP),
        .cc_busy (phy_rx_cc_busy),
        .done    (gap_done)
    );

`ifdef PHY_TX_TIMEOUT_EN
    logic [TMO_W-1:0] tmo_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt <= '0;
        end else if (state != ST_ACTIVE) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    assign tmo_hit = (tmo_cnt == TMO_W'(TMO_CYCLES - 1));
`else
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state               <= ST_IDLE;
            hr_pend             <= 1'b0;
            cr_pend             <= 1'b0;
            phy_tx_packet_en    <= 1'b0;
            phy_tx_packet_type  <= 3'd0;
            phy2pl_tx_done      <= 1'b0;
            phy2pl_tx_discarded <= 1'b0;
            phy2pl_reset_done   <= 1'b0;
            phy2pl_tx_err       <= 1'b0;
        end else begin
            phy_tx_packet_en    <= 1'b0;
            phy2pl_tx_done      <= 1'b0;
            phy2pl_tx_discarded <= 1'b0;
            phy2pl_reset_done   <= 1'b0;
            phy2pl_tx_err       <= 1'b0;

            // Launch clears the flag; a repeat pulse in that same cycle is absorbed.
            if (state == ST_START && phy_tx_packet_type == HARD_RESET_T) begin
                hr_pend <= 1'b0;
            end else if (pl2phy_hardreset_req) begin
                hr_pend <= 1'b1;
            end
            if (state == ST_START && phy_tx_packet_type == CABLE_RESET_T) begin
                cr_pend <= 1'b0;
            end else if (pl2phy_cablereset_req) begin
                cr_pend <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (hr_any) begin
                        phy_tx_packet_type <= HARD_RESET_T;
                        state              <= ST_GAP;
                    end else if (cr_any) begin
                        phy_tx_packet_type <= CABLE_RESET_T;
                        state              <= ST_GAP;
                    end else if (msg_req) begin
                        if (pl2phy_tx_sop_type > SOP_PP_T) begin
                            phy2pl_tx_discarded <= 1'b1;
                        end else begin
                            phy_tx_packet_type <= pl2phy_tx_sop_type;
                            state              <= ST_GAP;
                        end
                    end
                end
                ST_GAP: begin
                    if (msg_win && (phy_rx_cc_busy || hr_any || cr_any)) begin
                        phy2pl_tx_discarded <= 1'b1;
                        state               <= ST_IDLE;
                    end else if (gap_done) begin
                        state <= ST_START;
                    end
                end
                ST_START: begin
                    phy_tx_packet_en <= 1'b1;
                    state            <= ST_ACTIVE;
                end
                ST_ACTIVE: begin
                    if (phy_bmc_encoder_hold_lowbmc_done) begin
                        phy2pl_tx_done    <= msg_win;
                        phy2pl_reset_done <= !msg_win;
                        state             <= ST_IDLE;
                    end else if (tmo_hit) begin
                        phy2pl_tx_err <= 1'b1;
                        state         <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_phy_tx_sequencer.sv
// Bench for phy_tx_sequencer: directed scenarios then random traffic, every cycle checked against a job-level model.
module tb_phy_tx_sequencer;
    import phy_tx_sequencer_pkg::*;

    localparam int IFG = 8;
`ifdef PHY_TX_TIMEOUT_EN
    localparam int TMO    = 100;
    localparam bit TMO_EN = 1'b1;
`else
    localparam int TMO    = 0;
    localparam bit TMO_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pl2phy_tx_req = 1'b0;
    logic [2:0] pl2phy_tx_sop_type = 3'd0;
    logic       pl2phy_hardreset_req = 1'b0;
    logic       pl2phy_cablereset_req = 1'b0;
    logic       phy_rx_cc_busy = 1'b0;
    logic       phy_bmc_encoder_hold_lowbmc_done = 1'b0;
    logic       phy_tx_packet_en;
    logic [2:0] phy_tx_packet_type;
    logic       phy2pl_tx_done, phy2pl_tx_discarded, phy2pl_reset_done, phy2pl_tx_err, phy_tx_busy;

    always #5 clk = ~clk;

    phy_tx_sequencer #(
        .IFG_CYCLES (IFG),
        .IFG_W      (4)
`ifdef PHY_TX_TIMEOUT_EN
        ,
        .TMO_CYCLES (TMO),
        .TMO_W      (8)
`endif
    ) dut (
        .clk                              (clk),
        .rst_n                            (rst_n),
        .pl2phy_tx_req                    (pl2phy_tx_req),
        .pl2phy_tx_sop_type               (pl2phy_tx_sop_type),
        .pl2phy_hardreset_req             (pl2phy_hardreset_req),
        .pl2phy_cablereset_req            (pl2phy_cablereset_req),
        .phy_rx_cc_busy                   (phy_rx_cc_busy),
        .phy_bmc_encoder_hold_lowbmc_done (phy_bmc_encoder_hold_lowbmc_done),
        .phy_tx_packet_en                 (phy_tx_packet_en),
        .phy_tx_packet_type               (phy_tx_packet_type),
        .phy2pl_tx_done                   (phy2pl_tx_done),
        .phy2pl_tx_discarded              (phy2pl_tx_discarded),
        .phy2pl_reset_done                (phy2pl_reset_done),
        .phy2pl_tx_err                    (phy2pl_tx_err),
        .phy_tx_busy                      (phy_tx_busy)
    );

    int    n_cmp = 0;
    int    n_bad = 0;
    string phase = "reset";

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Job-level model: current job (-1 none, 0-2 message, 3/4 reset), quiet-run length, age since launch.
    int m_job, m_type, m_quiet, m_age;
    bit m_launch, m_hr, m_cr;
    bit x_en, x_done, x_disc, x_rdone, x_err;

    task automatic model_reset();
        m_job = -1; m_type = 0; m_quiet = 0; m_age = -1;
        m_launch = 0; m_hr = 0; m_cr = 0;
        x_en = 0; x_done = 0; x_disc = 0; x_rdone = 0; x_err = 0;
    endtask

    task automatic model_step(input bit req, input logic [2:0] sop, input bit hr, input bit cr,
                              input bit ccb, input bit hd);
        bit hr_now, cr_now, mask, clr_hr, clr_cr;
        hr_now = m_hr | hr;
        cr_now = m_cr | cr;
        mask   = x_done | x_disc | x_err;
        clr_hr = 0;
        clr_cr = 0;
        x_en = 0; x_done = 0; x_disc = 0; x_rdone = 0; x_err = 0;
        if (m_job < 0) begin
            if (hr_now) m_job = 3;
            else if (cr_now) m_job = 4;
            else if (req && !mask) begin
                if (sop > 3'd2) x_disc = 1;
                else m_job = int'(sop);
            end
            if (m_job >= 0) begin
                m_type  = m_job;
                m_quiet = 0;
            end
        end else if (m_launch) begin
            m_launch = 0;
            x_en     = 1;
            m_age    = 0;
            clr_hr   = (m_job == 3);
            clr_cr   = (m_job == 4);
        end else if (m_age >= 0) begin
            if (hd) begin
                if (m_job < 3) x_done = 1;
                else x_rdone = 1;
                m_job = -1;
                m_age = -1;
            end else if (TMO_EN && m_age == TMO - 1) begin
                x_err = 1;
                m_job = -1;
                m_age = -1;
            end else begin
                m_age++;
            end
        end else begin
            if (m_job < 3 && (ccb || hr_now || cr_now)) begin
                x_disc = 1;
                m_job  = -1;
            end else begin
                m_quiet = ccb ? 0 : m_quiet + 1;
                if (m_quiet == IFG) m_launch = 1;
            end
        end
        m_hr = clr_hr ? 1'b0 : hr_now;
        m_cr = clr_cr ? 1'b0 : cr_now;
    endtask

    function automatic logic [8:0] obs();
        return {phy_tx_packet_en, phy_tx_packet_type, phy2pl_tx_done, phy2pl_tx_discarded,
                phy2pl_reset_done, phy2pl_tx_err, phy_tx_busy};
    endfunction

    function automatic logic [8:0] expv();
        return {x_en, 3'(m_type), x_done, x_disc, x_rdone, x_err, (m_job >= 0)};
    endfunction

    task automatic tick(input bit req, input logic [2:0] sop, input bit hr, input bit cr,
                        input bit ccb, input bit hd);
        pl2phy_tx_req                    = req;
        pl2phy_tx_sop_type               = sop;
        pl2phy_hardreset_req             = hr;
        pl2phy_cablereset_req            = cr;
        phy_rx_cc_busy                   = ccb;
        phy_bmc_encoder_hold_lowbmc_done = hd;
        model_step(req, sop, hr, cr, ccb, hd);
        @(posedge clk);
        #1;
        check_eq(phase, 32'(obs()), 32'(expv()));
    endtask

    task automatic run_until_en(input bit req, input logic [2:0] sop, output int n);
        n = 0;
        do begin
            tick(req, sop, 0, 0, 0, 0);
            n++;
        end while (!phy_tx_packet_en && n < 4 * IFG);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no completion, required finish within time limit");
        $fatal(1, "bench time limit");
    end

    initial begin
        int  n;
        bit  req_on, drop_next;
        logic [2:0] req_sop;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_outs", 32'(obs()), 32'd0);
        rst_n = 1'b1;
        repeat (2) tick(0, 0, 0, 0, 0, 0);

        phase = "basic";
        run_until_en(1, 3'd1, n);
        check_eq("basic_lat", n, IFG + 2);
        check_eq("basic_type", 32'(phy_tx_packet_type), 1);
        repeat (49) tick(1, 3'd1, 0, 0, 0, 0);
        tick(1, 3'd1, 0, 0, 0, 1);
        check_eq("basic_done", 32'(phy2pl_tx_done), 1);
        check_eq("basic_busy", 32'(phy_tx_busy), 0);
        tick(1, 3'd1, 0, 0, 0, 0);
        repeat (3) tick(0, 0, 0, 0, 0, 0);

        phase = "collision";
        repeat (3) tick(1, 3'd0, 0, 0, 0, 0);
        tick(1, 3'd0, 0, 0, 1, 0);
        check_eq("coll_disc", 32'(phy2pl_tx_discarded), 1);
        repeat (2 * IFG) tick(0, 0, 0, 0, 0, 0);

        phase = "preempt";
        repeat (3) tick(1, 3'd2, 0, 0, 0, 0);
        tick(1, 3'd2, 1, 0, 0, 0);
        check_eq("pre_disc", 32'(phy2pl_tx_discarded), 1);
        run_until_en(0, 0, n);
        check_eq("pre_lat", n, IFG + 2);
        check_eq("pre_type", 32'(phy_tx_packet_type), 3);
        repeat (5) tick(0, 0, 0, 0, 0, 0);
        tick(0, 0, 0, 0, 0, 1);
        check_eq("pre_rdone", 32'(phy2pl_reset_done), 1);

        phase = "simul";
        tick(0, 0, 1, 1, 0, 0);
        run_until_en(0, 0, n);
        check_eq("sim_lat_hr", n + 1, IFG + 2);
        check_eq("sim_type_hr", 32'(phy_tx_packet_type), 3);
        tick(0, 0, 0, 0, 0, 1);
        check_eq("sim_rdone_hr", 32'(phy2pl_reset_done), 1);
        run_until_en(0, 0, n);
        check_eq("sim_lat_cr", n, IFG + 2);
        check_eq("sim_type_cr", 32'(phy_tx_packet_type), 4);
        tick(0, 0, 0, 0, 0, 1);
        check_eq("sim_rdone_cr", 32'(phy2pl_reset_done), 1);

        phase = "hr_in_active";
        run_until_en(1, 3'd0, n);
        tick(1, 3'd0, 1, 0, 0, 0);
        repeat (3) tick(1, 3'd0, 0, 0, 0, 0);
        tick(1, 3'd0, 0, 0, 0, 1);
        check_eq("act_done", 32'(phy2pl_tx_done), 1);
        run_until_en(0, 0, n);
        check_eq("act_hr_lat", n, IFG + 2);
        check_eq("act_hr_type", 32'(phy_tx_packet_type), 3);
        tick(0, 0, 0, 0, 0, 1);

        phase = "bad_sop";
        tick(1, 3'd5, 0, 0, 0, 0);
        check_eq("bad_disc", 32'(phy2pl_tx_discarded), 1);
        tick(1, 3'd5, 0, 0, 0, 0);
        tick(0, 0, 0, 0, 0, 0);

`ifdef PHY_TX_TIMEOUT_EN
        phase = "timeout";
        run_until_en(1, 3'd0, n);
        n = 0;
        do begin
            tick(1, 3'd0, 0, 0, 0, 0);
            n++;
        end while (!phy2pl_tx_err && n < 2 * TMO);
        check_eq("tmo_lat", n, TMO);
        check_eq("tmo_busy", 32'(phy_tx_busy), 0);
        tick(0, 0, 0, 0, 0, 0);
`endif

        phase = "async_rst";
        run_until_en(1, 3'd1, n);
        repeat (3) tick(1, 3'd1, 0, 0, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        check_eq("arst_outs", 32'(obs()), 32'd0);
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick(0, 0, 0, 0, 0, 1);
        repeat (4) tick(0, 0, 0, 0, 0, 0);

        phase = "random";
        req_on    = 0;
        drop_next = 0;
        req_sop   = 3'd0;
        for (int i = 0; i < 6000; i++) begin
            bit hr, cr, ccb, hd;
            if (drop_next) begin
                req_on    = 0;
                drop_next = 0;
            end
            if (!req_on && $urandom_range(0, 9) == 0) begin
                req_on  = 1;
                req_sop = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(3, 7))
                                                        : 3'($urandom_range(0, 2));
            end
            hr  = ($urandom_range(0, 79) == 0);
            cr  = ($urandom_range(0, 79) == 0);
            ccb = ($urandom_range(0, 24) == 0);
            hd  = ($urandom_range(0, 15) == 0);
            tick(req_on, req_sop, hr, cr, ccb, hd);
            if (req_on && (phy2pl_tx_done || phy2pl_tx_discarded || phy2pl_tx_err)) begin
                if ($urandom_range(0, 1) == 0) req_on = 0;
                else drop_next = 1;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
